i2c_tx: RTL and testbench
=========================

I2C_TX -- requirements
Module: i2c_tx

Interface
REQ-001 SHALL provide parameter HOLD_CYCLES, default 4: number of clk cycles SDA is held after a detected SCL fall before changing.
REQ-002 SHALL provide: clk  input  1  system clock; all logic on rising edge.
REQ-003 SHALL provide: rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL provide: i2c_sda_o  input  1  SDA bus level (read-back).
REQ-005 SHALL provide: i2c_scl_o  input  1  SCL bus level, generated externally.
REQ-006 SHALL provide: i2c_sda_i  output  1  SDA drive value, constant 0 (open-drain).
REQ-007 SHALL provide: i2c_sda_t  output  1  SDA tristate; 1 = released, 0 = pull low.
REQ-008 SHALL provide: tx_data  input  8  byte to send, MSB first.
REQ-009 SHALL provide: tx_valid  input  1  byte request, active-high.
REQ-010 SHALL provide: tx_ready  output  1  byte accepted this cycle when tx_valid & tx_ready.
REQ-011 SHALL provide: busy  output  1  high in any state other than IDLE.
REQ-012 SHALL provide: ack_ok  output  1  one-cycle pulse, slave ACK (SDA low) sampled.
REQ-013 SHALL provide: nack  output  1  one-cycle pulse, slave NACK (SDA high) sampled.
REQ-014 SHALL provide: arb_lost  output  1  one-cycle pulse, arbitration lost.

Function
REQ-015 SHALL register i2c_scl_o into scl_q; rise = scl & !scl_q, fall = !scl & scl_q.
REQ-016 SHALL implement states IDLE, SHIFT, ACK.
REQ-017 IDLE: tx_ready=1, i2c_sda_t=1; on tx_valid latch tx_data, bit index 7, go SHIFT; MSB driven on the next cycle.
REQ-018 Bit encoding: bit 0 -> i2c_sda_t=0; bit 1 -> i2c_sda_t=1 (released).
REQ-019 SHIFT: each rise counts one bit; at the fall following a counted rise, hold counter loads HOLD_CYCLES; SDA updates exactly HOLD_CYCLES+1 cycles after the fall cycle.
REQ-020 SHIFT: tx_ready=0; tx_valid ignored.
REQ-021 After the 8th counted rise, the following fall plus hold SHALL release SDA and enter ACK.
REQ-022 ACK: on rise sample i2c_sda_o; 0 -> ack_ok pulse, 1 -> nack pulse, same cycle.
REQ-023 ACK sample cycle: tx_ready = !i2c_sda_o; if ACK and tx_valid, latch new byte, go SHIFT, MSB driven HOLD_CYCLES+1 cycles after next fall.
REQ-024 ACK sample with NACK, or ACK without tx_valid: go IDLE, SDA stays released; no retry.
REQ-025 SDA SHALL never change while SCL high except on arbitration loss or reset.
REQ-026 HOLD_CYCLES=0 SHALL update SDA on the cycle after the fall cycle.
REQ-027 A fall with no preceding counted rise (e.g. SHIFT entered from IDLE) SHALL not change SDA.

Reset
REQ-028 rst SHALL force IDLE, i2c_sda_t=1, i2c_sda_i=0, tx_ready=1 on the next cycle, plus busy/ack_ok/nack/arb_lost=0, counters cleared.
REQ-029 rst mid-byte SHALL release SDA on the next cycle and discard the byte; tx_valid during rst ignored.

Configuration
REQ-030 Macro I2C_TX_ARB_LOSS_EN defined: in SHIFT, on rise, current bit 1 and i2c_sda_o=0 -> arb_lost pulse, SDA released next cycle, go IDLE.
REQ-031 Macro undefined: arb_lost tied 0, no read-back compare, byte always completes to ACK.

Verification
REQ-032 tx_data=0xA5, slave ACK -> i2c_sda_t per bit 1,0,1,0,0,1,0,1 → released,low,released,low,low,released,low,released; one ack_ok; IDLE.
REQ-033 tx_data=0x3C, slave NACK, tx_valid held high -> one nack, tx_ready=0 on sample, IDLE, SDA released.
REQ-034 Burst 0x12 then 0x34, both ACKed -> two accepts, two ack_ok, 18 SCL rises total, then IDLE.
REQ-035 rst asserted after 3rd rise of 0x00 -> i2c_sda_t=1 and busy=0 next cycle.
REQ-036 0xFF, bus forces SDA low on 3rd rise -> with macro, arb_lost pulse and IDLE; without it, 8 bits then ACK.
REQ-037 HOLD_CYCLES=4 -> every SDA transition occurs exactly 5 clk after the SCL fall cycle.

Source files
------------

// File: rtl/i2c_tx.sv
// i2c_tx: open-drain I2C byte transmitter slaved to an externally driven SCL.
// Define I2C_TX_ARB_LOSS_EN to enable arbitration-loss detection.
module i2c_tx #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       i2c_sda_o,
  input  logic       i2c_scl_o,
  output logic       i2c_sda_i,
  output logic       i2c_sda_t,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy,
  output logic       ack_ok,
  output logic       nack,
  output logic       arb_lost
);

`ifdef I2C_TX_ARB_LOSS_EN
  localparam bit ARB_EN = 1'b1;
`else
  localparam bit ARB_EN = 1'b0;
`endif

  localparam int HW =
    (HOLD_CYCLES < 1) ? 1 : $clog2(HOLD_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    ACK
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      data_q, data_d;
  logic [3:0]      idx_q, idx_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic            pend_q, pend_d;
  logic            rose_q, rose_d;
  logic            sda_t_q, sda_t_d;
  logic            scl_q;
  logic            rise, fall, step;
  logic [2:0]      bidx;

  assign rise = i2c_scl_o & ~scl_q;
  assign fall = ~i2c_scl_o & scl_q;
  assign bidx = idx_q[2:0] - 3'd1;

  assign i2c_sda_i = 1'b0;
  assign i2c_sda_t = sda_t_q;
  assign busy      = (state_q != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      hold_q  <= '0;
      pend_q  <= 1'b0;
      rose_q  <= 1'b0;
      sda_t_q <= 1'b1;
      scl_q   <= 1'b1;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      hold_q  <= hold_d;
      pend_q  <= pend_d;
      rose_q  <= rose_d;
      sda_t_q <= sda_t_d;
      scl_q   <= i2c_scl_o;
    end
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    idx_d    = idx_q;
    hold_d   = hold_q;
    pend_d   = pend_q;
    rose_d   = rose_q;
    sda_t_d  = sda_t_q;
    step     = 1'b0;
    tx_ready = 1'b0;
    ack_ok   = 1'b0;
    nack     = 1'b0;
    arb_lost = 1'b0;
    unique case (state_q)
      IDLE: begin
        tx_ready = 1'b1;
        sda_t_d  = 1'b1;
        rose_d   = 1'b0;
        pend_d   = 1'b0;
        hold_d   = '0;
        if (tx_valid) begin
          data_d  = tx_data;
          idx_d   = 4'd7;
          sda_t_d = tx_data[7];
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (rise) rose_d = 1'b1;
        if (fall && rose_q) begin
          rose_d = 1'b0;
          if (HOLD_CYCLES == 0) begin
            step = 1'b1;
          end else begin
            pend_d = 1'b1;
            hold_d = HW'(HOLD_CYCLES);
          end
        end
        if (pend_q) begin
          if (hold_q == HW'(1)) begin
            step   = 1'b1;
            pend_d = 1'b0;
            hold_d = '0;
          end else begin
            hold_d = hold_q - HW'(1);
          end
        end
        // idx counts bits still to drive; 8 means MSB pending after ACK
        if (step) begin
          if (idx_q == 4'd0) begin
            sda_t_d = 1'b1;
            state_d = ACK;
          end else begin
            idx_d   = idx_q - 4'd1;
            sda_t_d = data_q[bidx];
          end
        end
        if (ARB_EN && rise && sda_t_q && !i2c_sda_o) begin
          arb_lost = 1'b1;
          sda_t_d  = 1'b1;
          rose_d   = 1'b0;
          pend_d   = 1'b0;
          hold_d   = '0;
          state_d  = IDLE;
        end
      end
      ACK: begin
        sda_t_d = 1'b1;
        if (rise) begin
          tx_ready = ~i2c_sda_o;
          ack_ok   = ~i2c_sda_o;
          nack     = i2c_sda_o;
          if (!i2c_sda_o && tx_valid) begin
            data_d  = tx_data;
            idx_d   = 4'd8;
            rose_d  = 1'b1;
            state_d = SHIFT;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_i2c_tx.sv
// tb_i2c_tx: scoreboard bench for i2c_tx, bench acts as SCL master and slave.
// Runs a HOLD_CYCLES=4 and a HOLD_CYCLES=0 instance on the same bus stimulus.
module tb_i2c_tx;
  localparam int HOLD = 4;
  localparam int LOW  = 10;
  localparam int HIGH = 6;
  localparam int EV_ACK  = 2;
  localparam int EV_NACK = 3;
  localparam int EV_ARB  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl = 1'b1;
  logic       bus_low = 1'b0;
  logic       tx_valid = 1'b0;
  logic [7:0] tx_data = 8'h00;

  logic sda_o, sda_i, sda_t, tx_ready, busy;
  logic ack_ok, nack, arb_lost;
  logic sda_o2, sda_i2, sda_t2, tx_ready2, busy2;
  logic ack_ok2, nack2, arb_lost2;

  assign sda_o  = sda_t & ~bus_low;
  assign sda_o2 = sda_t2 & ~bus_low;

  always #5 clk = ~clk;

  i2c_tx #(.HOLD_CYCLES(HOLD)) dut (
    .clk(clk), .rst(rst),
    .i2c_sda_o(sda_o), .i2c_scl_o(scl),
    .i2c_sda_i(sda_i), .i2c_sda_t(sda_t),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .busy(busy),
    .ack_ok(ack_ok), .nack(nack), .arb_lost(arb_lost)
  );

  i2c_tx #(.HOLD_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst),
    .i2c_sda_o(sda_o2), .i2c_scl_o(scl),
    .i2c_sda_i(sda_i2), .i2c_sda_t(sda_t2),
    .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready2), .busy(busy2),
    .ack_ok(ack_ok2), .nack(nack2), .arb_lost(arb_lost2)
  );

  int total = 0;
  int bad   = 0;
  int q[$];
  int cyc = 0, fall_cyc = 0, rises = 0, acc = 0;
  logic scl_p = 1'b1, t1_p = 1'b1, t2_p = 1'b1;
  logic b1_p = 1'b0, b2_p = 1'b0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int ev(input logic a, input logic n,
                            input logic l, input logic t);
    if (a) return EV_ACK;
    if (n) return EV_NACK;
    if (l) return EV_ARB;
    return int'(t);
  endfunction

  always @(negedge clk) begin
    int   e;
    logic rc;
    cyc++;
    rc = scl && !scl_p;
    if (scl_p && !scl) fall_cyc = cyc;
    if (b1_p && busy && sda_t != t1_p)
      check("hold4", cyc - fall_cyc, HOLD + 1);
    if (b2_p && busy2 && sda_t2 != t2_p)
      check("hold0", cyc - fall_cyc, 1);
    if (rc && busy) rises++;
    if (tx_valid && tx_ready) acc++;
    if (ack_ok || nack) check("rdy_ack", tx_ready, !sda_o);
    if ((rc && busy) || ack_ok || nack || arb_lost) begin
      if (q.size() == 0) begin
        check("sb_underrun", ev(ack_ok, nack, arb_lost, sda_t), -1);
      end else begin
        e = q.pop_front();
        check("evt", ev(ack_ok, nack, arb_lost, sda_t), e);
        check("evt0", ev(ack_ok2, nack2, arb_lost2, sda_t2), e);
      end
    end
    scl_p = scl;
    t1_p  = sda_t;
    t2_p  = sda_t2;
    b1_p  = busy;
    b2_p  = busy2;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_byte(input logic [7:0] d);
    for (int i = 7; i >= 0; i--) q.push_back(int'(d[i]));
  endtask

  task automatic start_byte(input logic [7:0] d);
    tx_data  = d;
    tx_valid = 1'b1;
    tick();
    tx_valid = 1'b0;
  endtask

  task automatic scl_bit(input logic pull);
    scl = 1'b0;
    repeat (LOW) tick();
    scl = 1'b1;
    bus_low = pull;
    repeat (HIGH) tick();
    bus_low = 1'b0;
  endtask

  task automatic data_bits(input int pull_at);
    for (int b = 0; b < 8; b++) scl_bit(b == pull_at);
  endtask

  task automatic ack_phase(input logic pull);
    scl = 1'b0;
    repeat (LOW) tick();
    scl = 1'b1;
    bus_low = pull;
    tick();
    tx_valid = 1'b0;
    repeat (HIGH - 1) tick();
    bus_low = 1'b0;
  endtask

  task automatic idle_chk(input string tag);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sda"}, sda_t, 1);
    check({tag, "_busy0"}, busy2, 0);
    check({tag, "_sda0"}, sda_t2, 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog t=%0t", $time);
    $fatal(1, "timeout");
  end

  initial begin
    int r0, a0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_sda_t", sda_t, 1);
    check("rst_sda_i", sda_i, 0);
    check("rst_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_pulse", {ack_ok, nack, arb_lost}, 0);
    check("rst_sda_i0", sda_i2, 0);
    check("rst_ready0", tx_ready2, 1);

    // 0xA5 acknowledged
    push_byte(8'hA5);
    q.push_back(EV_ACK);
    start_byte(8'hA5);
    data_bits(-1);
    ack_phase(1'b1);
    tick();
    idle_chk("a5");

    // 0x3C with NACK while tx_valid stays high
    a0 = acc;
    push_byte(8'h3C);
    q.push_back(EV_NACK);
    start_byte(8'h3C);
    tx_data  = 8'h00;
    tx_valid = 1'b1;
    data_bits(-1);
    ack_phase(1'b0);
    idle_chk("nack");
    check("nack_acc", acc - a0, 1);
    repeat (4) tick();

    // burst 0x12 then 0x34
    r0 = rises;
    a0 = acc;
    push_byte(8'h12);
    q.push_back(EV_ACK);
    start_byte(8'h12);
    data_bits(-1);
    push_byte(8'h34);
    q.push_back(EV_ACK);
    tx_data  = 8'h34;
    tx_valid = 1'b1;
    ack_phase(1'b1);
    data_bits(-1);
    ack_phase(1'b1);
    tick();
    idle_chk("burst");
    check("burst_rises", rises - r0, 18);
    check("burst_acc", acc - a0, 2);

    // reset after third rise of 0x00
    repeat (3) q.push_back(0);
    start_byte(8'h00);
    scl_bit(1'b0);
    scl_bit(1'b0);
    scl = 1'b0;
    repeat (LOW) tick();
    scl = 1'b1;
    repeat (2) tick();
    check("pre_rst_busy", busy, 1);
    rst      = 1'b1;
    tx_data  = 8'hC3;
    tx_valid = 1'b1;
    tick();
    check("mid_rst_sda", sda_t, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", tx_ready, 1);
    tx_valid = 1'b0;
    rst      = 1'b0;
    tick();
    idle_chk("rst_tv");
    repeat (HIGH) tick();

    // 0xFF with bus pulled low on the third rise
`ifdef I2C_TX_ARB_LOSS_EN
    q.push_back(1);
    q.push_back(1);
    q.push_back(EV_ARB);
    start_byte(8'hFF);
    for (int b = 0; b < 3; b++) scl_bit(b == 2);
    idle_chk("arb");
`else
    push_byte(8'hFF);
    q.push_back(EV_ACK);
    start_byte(8'hFF);
    data_bits(2);
    ack_phase(1'b1);
    tick();
    idle_chk("noarb");
`endif

    repeat (4) tick();
    check("sb_left", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
